// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: datapath widths,
// sequencer state encodings and command kinds.
package alu_cmd_sequencer_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 5;

    localparam logic [1:0] SEQ_IDLE    = 2'd0;
    localparam logic [1:0] SEQ_ISSUE   = 2'd1;
    localparam logic [1:0] SEQ_CAPTURE = 2'd2;

    localparam logic CMD_ALU  = 1'b0;
    localparam logic CMD_LOAD = 1'b1;

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == {DATA_W{1'b0}});
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_regfile.sv
// Operand register file: two combinational read ports, one synchronous
// write port, synchronous reset to zero.
module alu_seq_regfile
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    input  logic                  wr_en,
    input  logic [REG_ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0]     wr_data
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Storage update; reset wins over any write presented on the same edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = regs_r[rd_addr_a];
    assign rd_data_b = regs_r[rd_addr_b];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer feeding a registered ALU: issues operands from the
// register file, captures the result one clock later and writes it back.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int NUM_REGS   = 4,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_kind_i,
    input  logic [OPCODE_W-1:0]   cmd_opcode_i,
    input  logic [REG_ADDR_W-1:0] cmd_dst_i,
    input  logic [REG_ADDR_W-1:0] cmd_src_a_i,
    input  logic [REG_ADDR_W-1:0] cmd_src_b_i,
    input  logic [DATA_W-1:0]     cmd_imm_i,
    output logic [OPCODE_W-1:0]   alu_opcode_o,
    output logic [DATA_W-1:0]     alu_a_o,
    output logic [DATA_W-1:0]     alu_b_o,
    input  logic [DATA_W-1:0]     alu_result_i,
    output logic                  res_valid_o,
    output logic [REG_ADDR_W-1:0] res_dst_o,
    output logic [DATA_W-1:0]     res_data_o,
    output logic                  res_zero_o,
    output logic                  busy_o
);

    logic [1:0]            state_r;
    logic [1:0]            state_nxt_s;
    logic [REG_ADDR_W-1:0] dst_r;
    logic [OPCODE_W-1:0]   alu_opcode_r;
    logic [DATA_W-1:0]     alu_a_r;
    logic [DATA_W-1:0]     alu_b_r;
    logic                  res_valid_r;
    logic [REG_ADDR_W-1:0] res_dst_r;
    logic [DATA_W-1:0]     res_data_r;
    logic                  res_zero_r;

    logic                  accept_s;
    logic                  accept_alu_s;
    logic                  accept_load_s;
    logic                  wr_en_s;
    logic [REG_ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0]     wr_data_s;
    logic [DATA_W-1:0]     rd_data_a_s;
    logic [DATA_W-1:0]     rd_data_b_s;

    assign accept_s      = cmd_valid_i && (state_r == SEQ_IDLE);
    assign accept_alu_s  = accept_s && (cmd_kind_i == CMD_ALU);
    assign accept_load_s = accept_s && (cmd_kind_i == CMD_LOAD);

    alu_seq_regfile #(
        .NUM_REGS   (NUM_REGS),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clock_i   (clock_i),
        .reset_i   (reset_i),
        .rd_addr_a (cmd_src_a_i),
        .rd_addr_b (cmd_src_b_i),
        .rd_data_a (rd_data_a_s),
        .rd_data_b (rd_data_b_s),
        .wr_en     (wr_en_s),
        .wr_addr   (wr_addr_s),
        .wr_data   (wr_data_s)
    );

    // Single write port shared by ALU write-back (CAPTURE) and load-immediate (IDLE).
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = cmd_dst_i;
        wr_data_s = cmd_imm_i;
        if (state_r == SEQ_CAPTURE) begin
            wr_en_s   = 1'b1;
            wr_addr_s = dst_r;
            wr_data_s = alu_result_i;
        end else if (accept_load_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = cmd_dst_i;
            wr_data_s = cmd_imm_i;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Next-state decode of the IDLE -> ISSUE -> CAPTURE cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SEQ_IDLE: begin
                if (accept_alu_s) begin
                    state_nxt_s = SEQ_ISSUE;
                end else begin
                    state_nxt_s = SEQ_IDLE;
                end
            end
            SEQ_ISSUE:   state_nxt_s = SEQ_CAPTURE;
            SEQ_CAPTURE: state_nxt_s = SEQ_IDLE;
            default:     state_nxt_s = SEQ_IDLE;
        endcase
    end

    // State and destination latch; a reset mid-command simply drops it.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= SEQ_IDLE;
            dst_r   <= {REG_ADDR_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (accept_alu_s) begin
                dst_r <= cmd_dst_i;
            end
        end
    end

    // ALU drive registers: loaded only on ALU accept, otherwise held stable.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            alu_opcode_r <= {OPCODE_W{1'b0}};
            alu_a_r      <= {DATA_W{1'b0}};
            alu_b_r      <= {DATA_W{1'b0}};
        end else if (accept_alu_s) begin
            alu_opcode_r <= cmd_opcode_i;
            alu_a_r      <= rd_data_a_s;
            alu_b_r      <= rd_data_b_s;
        end
    end

    // Result report mirrors every register-file write, one cycle later.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            res_valid_r <= 1'b0;
            res_dst_r   <= {REG_ADDR_W{1'b0}};
            res_data_r  <= {DATA_W{1'b0}};
            res_zero_r  <= 1'b1;
        end else begin
            res_valid_r <= wr_en_s;
            if (wr_en_s) begin
                res_dst_r  <= wr_addr_s;
                res_data_r <= wr_data_s;
                res_zero_r <= is_zero(wr_data_s);
            end
        end
    end

    assign cmd_ready_o  = (state_r == SEQ_IDLE);
    assign busy_o       = (state_r != SEQ_IDLE);
    assign alu_opcode_o = alu_opcode_r;
    assign alu_a_o      = alu_a_r;
    assign alu_b_o      = alu_b_r;
    assign res_valid_o  = res_valid_r;
    assign res_dst_o    = res_dst_r;
    assign res_data_o   = res_data_r;
    assign res_zero_o   = res_zero_r;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural registered ALU
// attached to its ALU ports.
module tb_alu_cmd_sequencer;

    // ALU opcode encodings assumed by the reference ALU below.
    localparam logic [2:0] ALU_PASS_A     = 3'd0;
    localparam logic [2:0] ALU_ADD        = 3'd1;
    localparam logic [2:0] ALU_SUBTRACT   = 3'd2;
    localparam logic [2:0] ALU_INCREMENT  = 3'd3;
    localparam logic [1:0] ALU_NO_SHIFT   = 2'd0;
    localparam logic [1:0] ALU_LEFT_SHIFT = 2'd1;
    localparam logic [1:0] ALU_RIGHT_SHIFT = 2'd2;
    localparam logic [1:0] ALU_PASS_ZEROS = 2'd3;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic        cmd_kind_i = 1'b0;
    logic [4:0]  cmd_opcode_i = 5'd0;
    logic [1:0]  cmd_dst_i = 2'd0;
    logic [1:0]  cmd_src_a_i = 2'd0;
    logic [1:0]  cmd_src_b_i = 2'd0;
    logic [31:0] cmd_imm_i = 32'd0;
    logic [4:0]  alu_opcode_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic [31:0] alu_result_i = 32'd0;
    logic        res_valid_o;
    logic [1:0]  res_dst_o;
    logic [31:0] res_data_o;
    logic        res_zero_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_fail = 0;

    alu_cmd_sequencer dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_kind_i   (cmd_kind_i),
        .cmd_opcode_i (cmd_opcode_i),
        .cmd_dst_i    (cmd_dst_i),
        .cmd_src_a_i  (cmd_src_a_i),
        .cmd_src_b_i  (cmd_src_b_i),
        .cmd_imm_i    (cmd_imm_i),
        .alu_opcode_o (alu_opcode_o),
        .alu_a_o      (alu_a_o),
        .alu_b_o      (alu_b_o),
        .alu_result_i (alu_result_i),
        .res_valid_o  (res_valid_o),
        .res_dst_o    (res_dst_o),
        .res_data_o   (res_data_o),
        .res_zero_o   (res_zero_o),
        .busy_o       (busy_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic logic [31:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (op[4:2])
            ALU_PASS_A:    r = a;
            ALU_ADD:       r = a + b;
            ALU_SUBTRACT:  r = a - b;
            ALU_INCREMENT: r = a + 32'd1;
            default:       r = 32'd0;
        endcase
        case (op[1:0])
            ALU_NO_SHIFT:    return r;
            ALU_LEFT_SHIFT:  return r << 1;
            ALU_RIGHT_SHIFT: return r >> 1;
            default:         return 32'd0;
        endcase
    endfunction

    // Registered ALU: output reflects inputs sampled at the previous edge.
    always @(posedge clock_i) alu_result_i <= alu_model(alu_opcode_o, alu_a_o, alu_b_o);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive_load(input logic [1:0] dst, input logic [31:0] imm);
        cmd_valid_i = 1'b1;
        cmd_kind_i  = 1'b1;
        cmd_dst_i   = dst;
        cmd_imm_i   = imm;
    endtask

    task automatic drive_alu(input logic [4:0] op, input logic [1:0] dst,
                             input logic [1:0] sa, input logic [1:0] sb);
        cmd_valid_i  = 1'b1;
        cmd_kind_i   = 1'b0;
        cmd_opcode_i = op;
        cmd_dst_i    = dst;
        cmd_src_a_i  = sa;
        cmd_src_b_i  = sb;
    endtask

    // Issue one ALU command from IDLE and follow it through to its result.
    task automatic run_alu(input string tag, input logic [4:0] op, input logic [1:0] dst,
                           input logic [1:0] sa, input logic [1:0] sb,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic [31:0] exp_res);
        drive_alu(op, dst, sa, sb);
        chk({tag, " ready_at_accept"}, {31'd0, cmd_ready_o}, 32'd1);
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        chk({tag, " issue_ready"}, {31'd0, cmd_ready_o}, 32'd0);
        chk({tag, " issue_busy"}, {31'd0, busy_o}, 32'd1);
        chk({tag, " issue_opcode"}, {27'd0, alu_opcode_o}, {27'd0, op});
        chk({tag, " issue_a"}, alu_a_o, exp_a);
        chk({tag, " issue_b"}, alu_b_o, exp_b);
        @(negedge clock_i);
        chk({tag, " capture_ready"}, {31'd0, cmd_ready_o}, 32'd0);
        chk({tag, " capture_valid"}, {31'd0, res_valid_o}, 32'd0);
        @(negedge clock_i);
        chk({tag, " res_valid"}, {31'd0, res_valid_o}, 32'd1);
        chk({tag, " res_dst"}, {30'd0, res_dst_o}, {30'd0, dst});
        chk({tag, " res_data"}, res_data_o, exp_res);
        chk({tag, " res_zero"}, {31'd0, res_zero_o}, {31'd0, exp_res == 32'd0});
        chk({tag, " ready_back"}, {31'd0, cmd_ready_o}, 32'd1);
    endtask

    initial begin
        int accepts;
        int n_res;
        logic [31:0] chain [4];

        // Reset state
        repeat (2) @(negedge clock_i);
        chk("rst ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst res_valid", {31'd0, res_valid_o}, 32'd0);
        chk("rst res_zero", {31'd0, res_zero_o}, 32'd1);
        chk("rst res_data", res_data_o, 32'd0);
        chk("rst alu_a", alu_a_o, 32'd0);
        chk("rst alu_opcode", {27'd0, alu_opcode_o}, 32'd0);
        reset_i = 1'b0;

        // Back-to-back loads
        drive_load(2'd0, 32'd5);
        @(negedge clock_i);
        chk("ld0 valid", {31'd0, res_valid_o}, 32'd1);
        chk("ld0 dst", {30'd0, res_dst_o}, 32'd0);
        chk("ld0 data", res_data_o, 32'd5);
        chk("ld0 zero", {31'd0, res_zero_o}, 32'd0);
        chk("ld0 ready", {31'd0, cmd_ready_o}, 32'd1);
        drive_load(2'd1, 32'd3);
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        chk("ld1 valid", {31'd0, res_valid_o}, 32'd1);
        chk("ld1 dst", {30'd0, res_dst_o}, 32'd1);
        chk("ld1 data", res_data_o, 32'd3);
        chk("ld1 ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("ld1 alu_a_untouched", alu_a_o, 32'd0);
        @(negedge clock_i);
        chk("ld idle valid", {31'd0, res_valid_o}, 32'd0);

        run_alu("add", {ALU_ADD, ALU_NO_SHIFT}, 2'd2, 2'd0, 2'd1, 32'd5, 32'd3, 32'd8);
        run_alu("sub_shl", {ALU_SUBTRACT, ALU_LEFT_SHIFT}, 2'd3, 2'd1, 2'd0,
                32'd3, 32'd5, 32'hFFFF_FFFC);
        run_alu("pass_zero", {ALU_PASS_A, ALU_PASS_ZEROS}, 2'd3, 2'd3, 2'd3,
                32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd0);
        @(negedge clock_i);
        chk("idle hold alu_a", alu_a_o, 32'hFFFF_FFFC);
        chk("single pulse", {31'd0, res_valid_o}, 32'd0);

        // Streaming dependent chain r0 = r0 + r1 with valid held high
        accepts = 0;
        n_res = 0;
        drive_alu({ALU_ADD, ALU_NO_SHIFT}, 2'd0, 2'd0, 2'd1);
        for (int i = 0; i < 13; i++) begin
            if (i == 12) cmd_valid_i = 1'b0;
            if (cmd_valid_i && cmd_ready_o) accepts++;
            @(negedge clock_i);
            if (res_valid_o && n_res < 4) begin
                chain[n_res] = res_data_o;
                n_res++;
            end
        end
        chk("stream accepts", accepts, 32'd4);
        chk("stream results", n_res, 32'd4);
        chk("chain 0", chain[0], 32'd8);
        chk("chain 1", chain[1], 32'd11);
        chk("chain 2", chain[2], 32'd14);
        chk("chain 3", chain[3], 32'd17);

        // Reset asserted during CAPTURE of an r2 write
        drive_alu({ALU_ADD, ALU_NO_SHIFT}, 2'd2, 2'd0, 2'd1);
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        chk("rstcap issue_a", alu_a_o, 32'd17);
        @(negedge clock_i);
        chk("rstcap in_capture", {31'd0, busy_o}, 32'd1);
        reset_i = 1'b1;
        @(negedge clock_i);
        reset_i = 1'b0;
        chk("rstcap no_valid", {31'd0, res_valid_o}, 32'd0);
        chk("rstcap ready", {31'd0, cmd_ready_o}, 32'd1);
        chk("rstcap busy", {31'd0, busy_o}, 32'd0);
        @(negedge clock_i);
        chk("rstcap still_no_valid", {31'd0, res_valid_o}, 32'd0);
        run_alu("rd_r2", {ALU_PASS_A, ALU_NO_SHIFT}, 2'd3, 2'd2, 2'd2, 32'd0, 32'd0, 32'd0);

        // Self-referencing op on r1, then a load at N+3 overrides it
        drive_load(2'd1, 32'd3);
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        chk("reload r1", res_data_o, 32'd3);
        run_alu("self", {ALU_ADD, ALU_NO_SHIFT}, 2'd1, 2'd1, 2'd1, 32'd3, 32'd3, 32'd6);
        drive_load(2'd1, 32'hDEAD_BEEF);
        @(negedge clock_i);
        cmd_valid_i = 1'b0;
        chk("ovr valid", {31'd0, res_valid_o}, 32'd1);
        chk("ovr dst", {30'd0, res_dst_o}, 32'd1);
        chk("ovr data", res_data_o, 32'hDEAD_BEEF);
        run_alu("rd_r1", {ALU_INCREMENT, ALU_RIGHT_SHIFT}, 2'd0, 2'd1, 2'd0,
                32'hDEAD_BEEF, 32'd0, 32'h6F56_DF78);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
